// File: rtl/set_assoc_cache_wb.sv
// N-way set-associative, write-back, write-allocate line cache with true-LRU
// replacement. It sits between a line-granular requester and a backing memory
// port. A dirty victim is written back before its way is reused. Read misses
// refill from memory; write misses install the full line without a refill.
module set_assoc_cache_wb #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 512,
  parameter int OFFSET_BITS = 6,
  parameter int NUM_SETS    = 128,
  parameter int NUM_WAYS    = 4,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [LINE_W-1:0] resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [3:0]        state_debug
);

  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS   = ADDR_W - OFFSET_BITS - INDEX_BITS;
  localparam int WAY_W      = $clog2(NUM_WAYS);

  typedef logic [NUM_WAYS-1:0][WAY_W-1:0] age_vec_t;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_LOOKUP      = 4'd1,
    S_WRITEBACK   = 4'd2,
    S_REFILL_REQ  = 4'd3,
    S_REFILL_WAIT = 4'd4,
    S_RESPOND     = 4'd5
  } state_t;

  state_t state, state_nxt;

  // Line storage (data) and per-line bookkeeping (control)
  logic [TAG_BITS-1:0] tag_mem    [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   data_mem   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_bits [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_bits [NUM_SETS];
  age_vec_t            age_mem    [NUM_SETS];

  // Request latched at acceptance; the victim is chosen once, in LOOKUP
  logic                  lat_write;
  logic [TAG_BITS-1:0]   lat_tag;
  logic [INDEX_BITS-1:0] lat_index;
  logic [LINE_W-1:0]     lat_wdata;
  logic [WAY_W-1:0]      victim_way;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             has_invalid;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] miss_way;
  logic             miss_dirty;

  logic              install_en;
  logic [WAY_W-1:0]  install_way;
  logic              install_dirty;
  logic [LINE_W-1:0] install_data;
  logic              touch_en;
  logic [WAY_W-1:0]  touch_way;
  logic              clean_en;

  logic unused_offset;
  assign unused_offset = ^req_addr[OFFSET_BITS-1:0];

  // The touched way becomes youngest; every way younger than it ages by one
  function automatic age_vec_t lru_touch(input age_vec_t ages, input logic [WAY_W-1:0] way);
    age_vec_t res;
    res = ages;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (ages[w] < ages[way]) res[w] = ages[w] + 1'b1;
    end
    res[way] = '0;
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Tag compare across all ways of the latched set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_bits[lat_index][w] && (tag_mem[lat_index][w] == lat_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: the lowest-index invalid way, else the oldest way
  always_comb begin
    has_invalid = 1'b0;
    inv_way     = '0;
    lru_way     = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_bits[lat_index][w]) begin
        has_invalid = 1'b1;
        inv_way     = WAY_W'(w);
      end
      if (age_mem[lat_index][w] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
    end
    miss_way   = has_invalid ? inv_way : lru_way;
    miss_dirty = valid_bits[lat_index][miss_way] && dirty_bits[lat_index][miss_way];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:        if (req_valid) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (hit)            state_nxt = S_RESPOND;
        else if (miss_dirty) state_nxt = S_WRITEBACK;
        else if (lat_write) state_nxt = S_RESPOND;
        else                state_nxt = S_REFILL_REQ;
      end
      S_WRITEBACK:   if (mem_req_ready) state_nxt = lat_write ? S_RESPOND : S_REFILL_REQ;
      S_REFILL_REQ:  if (mem_req_ready) state_nxt = S_REFILL_WAIT;
      S_REFILL_WAIT: if (mem_resp_valid) state_nxt = S_RESPOND;
      S_RESPOND:     state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs and memory request payload, decoded from state
  always_comb begin
    req_ready     = (state == S_IDLE);
    resp_valid    = (state == S_RESPOND);
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state)
      S_WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_mem[lat_index][victim_way], lat_index, {OFFSET_BITS{1'b0}}};
        mem_req_wdata = data_mem[lat_index][victim_way];
      end
      S_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {lat_tag, lat_index, {OFFSET_BITS{1'b0}}};
      end
      default: ;
    endcase
  end

  // Line install / LRU touch decisions; a write hit is an install onto the hit way
  always_comb begin
    install_en    = 1'b0;
    install_way   = victim_way;
    install_dirty = 1'b0;
    install_data  = lat_wdata;
    touch_en      = 1'b0;
    touch_way     = victim_way;
    clean_en      = 1'b0;
    case (state)
      S_LOOKUP: begin
        if (hit) begin
          touch_en      = 1'b1;
          touch_way     = hit_way;
          install_en    = lat_write;
          install_way   = hit_way;
          install_dirty = 1'b1;
        end else if (!miss_dirty && lat_write) begin
          touch_en      = 1'b1;
          touch_way     = miss_way;
          install_en    = 1'b1;
          install_way   = miss_way;
          install_dirty = 1'b1;
        end
      end
      S_WRITEBACK: begin
        if (mem_req_ready) begin
          clean_en      = 1'b1;
          install_en    = lat_write;
          install_dirty = 1'b1;
          touch_en      = lat_write;
        end
      end
      S_REFILL_WAIT: begin
        if (mem_resp_valid) begin
          install_en   = 1'b1;
          install_data = mem_resp_rdata;
          touch_en     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Request latch, victim capture and line storage (no reset: data only)
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      lat_write <= req_write;
      lat_tag   <= req_addr[ADDR_W-1 -: TAG_BITS];
      lat_index <= req_addr[OFFSET_BITS +: INDEX_BITS];
      lat_wdata <= req_wdata;
    end
    if (state == S_LOOKUP) victim_way <= miss_way;
    if (install_en) begin
      tag_mem[lat_index][install_way]  <= lat_tag;
      data_mem[lat_index][install_way] <= install_data;
    end
  end

  // Valid/dirty/LRU state, response registers and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_bits[s] <= '0;
        dirty_bits[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_mem[s][w] <= WAY_W'(w);
      end
      hit_count  <= '0;
      miss_count <= '0;
      resp_hit   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (clean_en) dirty_bits[lat_index][victim_way] <= 1'b0;
      if (install_en) begin
        valid_bits[lat_index][install_way] <= 1'b1;
        dirty_bits[lat_index][install_way] <= install_dirty;
      end
      if (touch_en) age_mem[lat_index] <= lru_touch(age_mem[lat_index], touch_way);
      if (state == S_LOOKUP) begin
        resp_hit <= hit;
        if (hit && !lat_write) resp_rdata <= data_mem[lat_index][hit_way];
      end
      if (state == S_REFILL_WAIT && mem_resp_valid) resp_rdata <= mem_resp_rdata;
      if (state == S_RESPOND) begin
        if (resp_hit) hit_count  <= sat_inc(hit_count);
        else          miss_count <= sat_inc(miss_count);
      end
    end
  end

  assign state_debug = state;

endmodule

// File: tb/tb_set_assoc_cache_wb.sv
// Scoreboard bench for set_assoc_cache_wb: expected responses and memory
// requests are queued when stimulus is issued and checked when they appear.
`timescale 1ns/1ps
module tb_set_assoc_cache_wb;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 512;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LINE_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic              resp_hit;
  logic [LINE_W-1:0] resp_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_rdata;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
  logic [3:0]        state_debug;

  set_assoc_cache_wb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .hit_count(hit_count), .miss_count(miss_count), .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  typedef struct { logic hit; logic rd; logic [LINE_W-1:0] data; } resp_t;
  typedef struct { logic wr; logic [ADDR_W-1:0] addr; logic [LINE_W-1:0] data; } mreq_t;

  resp_t resp_q[$];
  mreq_t mem_q[$];
  int total = 0;
  int bad = 0;
  int mem_hs = 0;
  int ready_delay = 0;
  int refill_delay = 0;
  logic [LINE_W-1:0] refill_data = '0;
  bit pend_refill = 1'b0;
  int refill_cnt = 0;
  int wait_cnt = 0;

  function automatic logic [ADDR_W-1:0] la(input int tag, input int set);
    return (ADDR_W'(tag) << 13) | (ADDR_W'(set) << 6);
  endfunction

  function automatic logic [LINE_W-1:0] pat(input logic [31:0] v);
    return {16{v}};
  endfunction

  function automatic mreq_t mk_mreq(input logic wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    mreq_t m;
    m.wr = wr; m.addr = a; m.data = d;
    return m;
  endfunction

  function automatic resp_t mk_resp(input logic h, input logic rd, input logic [LINE_W-1:0] d);
    resp_t r;
    r.hit = h; r.rd = rd; r.data = d;
    return r;
  endfunction

  // Response scoreboard
  initial begin : mon_resp
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        total++;
        if (resp_q.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected: resp_valid=1 hit=%b, required no response", resp_hit);
        end else begin
          e = resp_q.pop_front();
          if (resp_hit !== e.hit) begin
            bad++;
            $display("FAIL resp_hit: got %b required %b", resp_hit, e.hit);
          end
          if (e.rd) begin
            total++;
            if (resp_rdata !== e.data) begin
              bad++;
              $display("FAIL resp_rdata: got %h required %h", resp_rdata, e.data);
            end
          end
        end
      end
    end
  end

  // Memory model: delayed ready, refill data after refill_delay cycles
  initial begin : mem_model
    mreq_t e;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (pend_refill) begin
        if (refill_cnt >= refill_delay) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = refill_data;
          pend_refill = 1'b0;
        end else refill_cnt++;
      end
      if (mem_req_valid === 1'b1) begin
        mem_req_ready = (wait_cnt >= ready_delay);
        if (mem_req_ready) begin
          mem_hs++;
          wait_cnt = 0;
          total++;
          if (mem_q.size() == 0) begin
            bad++;
            $display("FAIL mem_unexpected: write=%b addr=%h, required no memory request", mem_req_write, mem_req_addr);
          end else begin
            e = mem_q.pop_front();
            if (mem_req_write !== e.wr || mem_req_addr !== e.addr || (e.wr && mem_req_wdata !== e.data)) begin
              bad++;
              $display("FAIL mem_req: got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h",
                       mem_req_write, mem_req_addr, mem_req_wdata, e.wr, e.addr, e.data);
            end
          end
          if (mem_req_write === 1'b0) begin
            pend_refill = 1'b1;
            refill_cnt = 0;
          end
        end else wait_cnt++;
      end else begin
        mem_req_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic issue(input bit wr, input int tag, input int set, input logic [LINE_W-1:0] wd);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = la(tag, set) | ADDR_W'(6'h15);
    req_wdata = wd;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL req_accept: req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    total++;
    if (resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, lat);
    end
  endtask

  task automatic test_reset();
    total++;
    if (state_debug !== 4'd0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: state=%0d req_ready=%b resp_valid=%b mem_req_valid=%b required 0/1/0/0",
               state_debug, req_ready, resp_valid, mem_req_valid);
    end
    total++;
    if (hit_count !== '0 || miss_count !== '0 || resp_hit !== 1'b0 || resp_rdata !== '0) begin
      bad++;
      $display("FAIL reset_out: hits=%0d misses=%0d resp_hit=%b required all 0", hit_count, miss_count, resp_hit);
    end
  endtask

  task automatic test_fill();
    int lat;
    logic [31:0] v [4];
    v[0] = 32'hAAAA; v[1] = 32'hBBBB; v[2] = 32'hCCCC; v[3] = 32'hDDDD;
    for (int i = 0; i < 4; i++) begin
      resp_q.push_back(mk_resp(1'b0, 1'b0, '0));
      issue(1'b1, 10 + i, 5, pat(v[i]));
      wait_resp(lat);
      total++;
      if (lat != 2) begin bad++; $display("FAIL fill_latency: got %0d required 2", lat); end
    end
    @(negedge clk);
    total++;
    if (miss_count !== 32'd4 || hit_count !== 32'd0 || mem_hs != 0) begin
      bad++;
      $display("FAIL fill_counts: misses=%0d hits=%0d mem=%0d required 4/0/0", miss_count, hit_count, mem_hs);
    end
  endtask

  task automatic test_read_hits();
    int lat;
    logic [31:0] v [4];
    v[0] = 32'hAAAA; v[1] = 32'hBBBB; v[2] = 32'hCCCC; v[3] = 32'hDDDD;
    for (int i = 0; i < 4; i++) begin
      resp_q.push_back(mk_resp(1'b1, 1'b1, pat(v[i])));
      issue(1'b0, 10 + i, 5, '0);
      wait_resp(lat);
      total++;
      if (lat != 2) begin bad++; $display("FAIL hit_latency: got %0d required 2", lat); end
    end
    @(negedge clk);
    total++;
    if (hit_count !== 32'd4 || miss_count !== 32'd4) begin
      bad++;
      $display("FAIL hit_counts: hits=%0d misses=%0d required 4/4", hit_count, miss_count);
    end
  endtask

  task automatic test_evict_write();
    int lat;
    mem_q.push_back(mk_mreq(1'b1, la(10, 5), pat(32'hAAAA)));
    resp_q.push_back(mk_resp(1'b0, 1'b0, '0));
    issue(1'b1, 20, 5, pat(32'h2020));
    wait_resp(lat);
    @(negedge clk);
    total++;
    if (mem_hs != 1 || mem_q.size() != 0 || miss_count !== 32'd5) begin
      bad++;
      $display("FAIL evict_write: mem=%0d pending=%0d misses=%0d required 1/0/5", mem_hs, mem_q.size(), miss_count);
    end
  endtask

  task automatic test_refill();
    int lat;
    refill_delay = 3;
    refill_data = pat(32'hCAFEBABE);
    mem_q.push_back(mk_mreq(1'b1, la(11, 5), pat(32'hBBBB)));
    mem_q.push_back(mk_mreq(1'b0, la(10, 5), '0));
    resp_q.push_back(mk_resp(1'b0, 1'b1, pat(32'hCAFEBABE)));
    issue(1'b0, 10, 5, '0);
    wait_resp(lat);
    resp_q.push_back(mk_resp(1'b1, 1'b1, pat(32'hCAFEBABE)));
    issue(1'b0, 10, 5, '0);
    wait_resp(lat);
    total++;
    if (lat != 2) begin bad++; $display("FAIL rehit_latency: got %0d required 2", lat); end
    @(negedge clk);
    total++;
    if (hit_count !== 32'd5 || miss_count !== 32'd6 || mem_q.size() != 0) begin
      bad++;
      $display("FAIL refill_counts: hits=%0d misses=%0d pending=%0d required 5/6/0", hit_count, miss_count, mem_q.size());
    end
  endtask

  task automatic test_wb_stall();
    int lat;
    int n;
    logic [ADDR_W-1:0] a0;
    logic [LINE_W-1:0] d0;
    ready_delay = 5;
    mem_q.push_back(mk_mreq(1'b1, la(12, 5), pat(32'hCCCC)));
    resp_q.push_back(mk_resp(1'b0, 1'b0, '0));
    fork
      begin
        issue(1'b1, 30, 5, pat(32'h3030));
        wait_resp(lat);
      end
      begin
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        a0 = mem_req_addr;
        d0 = mem_req_wdata;
        for (int i = 0; i < 5; i++) begin
          total++;
          if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_req_addr !== a0 ||
              mem_req_wdata !== d0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL wb_stall: cycle %0d valid=%b write=%b addr=%h req_ready=%b resp_valid=%b required 1/1/%h/0/0",
                     i, mem_req_valid, mem_req_write, mem_req_addr, req_ready, resp_valid, a0);
          end
          @(negedge clk);
        end
      end
    join
    ready_delay = 0;
    @(negedge clk);
    total++;
    if (miss_count !== 32'd7 || mem_q.size() != 0) begin
      bad++;
      $display("FAIL wb_stall_done: misses=%0d pending=%0d required 7/0", miss_count, mem_q.size());
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int n;
    refill_delay = 6;
    refill_data = pat(32'hDEAD0040);
    mem_q.push_back(mk_mreq(1'b1, la(13, 5), pat(32'hDDDD)));
    mem_q.push_back(mk_mreq(1'b0, la(40, 5), '0));
    issue(1'b0, 40, 5, '0);
    n = 0;
    while (state_debug !== 4'd4 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (state_debug !== 4'd4) begin
      bad++;
      $display("FAIL reach_refill_wait: state=%0d required 4", state_debug);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (state_debug !== 4'd0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0 ||
        hit_count !== '0 || miss_count !== '0) begin
      bad++;
      $display("FAIL abort_reset: state=%0d req_ready=%b mem_req_valid=%b hits=%0d misses=%0d required 0/1/0/0/0",
               state_debug, req_ready, mem_req_valid, hit_count, miss_count);
    end
    n = 0;
    while (pend_refill && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (state_debug !== 4'd0 || pend_refill) begin
      bad++;
      $display("FAIL late_refill: state=%0d pending=%b required 0/0", state_debug, pend_refill);
    end
    refill_delay = 0;
    refill_data = pat(32'h00001234);
    mem_q.push_back(mk_mreq(1'b0, la(12, 5), '0));
    resp_q.push_back(mk_resp(1'b0, 1'b1, pat(32'h00001234)));
    issue(1'b0, 12, 5, '0);
    wait_resp(lat);
    @(negedge clk);
    total++;
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
      bad++;
      $display("FAIL post_reset_miss: misses=%0d hits=%0d required 1/0", miss_count, hit_count);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_fill();
    test_read_hits();
    test_evict_write();
    test_refill();
    test_wb_stall();
    test_reset_abort();
    repeat (3) @(negedge clk);
    total++;
    if (resp_q.size() != 0 || mem_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: responses=%0d mem_requests=%0d required 0/0", resp_q.size(), mem_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
